// File: rtl/time_pkg.sv
// Shared constants, set-FSM state type and load range check for the time keeper.
// Hour range follows TIME_24H_EN (defined: 0..23, undefined: 1..12).
package time_pkg;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;

`ifdef TIME_24H_EN
  localparam logic [7:0] HOUR_MIN = 8'd0;
  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] HOUR_RST = 8'd0;
`else
  localparam logic [7:0] HOUR_MIN = 8'd1;
  localparam logic [7:0] HOUR_MAX = 8'd12;
  localparam logic [7:0] HOUR_RST = 8'd12;
`endif

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } set_state_e;

  // The 24h lower bound is zero, so only the 12h build needs a lower-bound test.
  function automatic logic fields_ok(input logic [7:0] s, input logic [7:0] m,
                                     input logic [7:0] h);
    logic hour_ok;
`ifdef TIME_24H_EN
    hour_ok = (h <= HOUR_MAX);
`else
    hour_ok = (h >= HOUR_MIN) && (h <= HOUR_MAX);
`endif
    return (s <= SEC_MAX) && (m <= MIN_MAX) && hour_ok;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Second prescaler: counts 0..SYSCLKHZ-1 while enabled, with a synchronous clear.
// sec_due flags that the coming edge wraps the prescaler and completes a second.
module tick_gen #(
  parameter int SYSCLKHZ = 5000_0000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sec_due
);

  localparam int CNT_W = (SYSCLKHZ > 1) ? $clog2(SYSCLKHZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYSCLKHZ - 1);

  logic [CNT_W-1:0] count_r;
  logic             at_last_s;

  // Wrap detection on the current count.
  always_comb begin
    at_last_s = (count_r == CNT_LAST);
    sec_due   = en && at_last_s;
  end

  // Prescaler register; a clear wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en) begin
      if (at_last_s) begin
        count_r <= {CNT_W{1'b0}};
      end else begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Real-time clock (sec/min/hour) with a ready/valid time-load port and tick strobes.
// Build option TIME_24H_EN selects 24-hour counting instead of 12-hour.
module time_keeper
  import time_pkg::*;
#(
  parameter int SYSCLKHZ = 5000_0000
) (
  input  logic       clk,
  input  logic       Rst_n,
  input  logic       En,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_sec,
  input  logic [7:0] set_min,
  input  logic [7:0] set_hour,
  output logic       set_err,
  output logic [7:0] sec_data,
  output logic [7:0] min_data,
  output logic [7:0] hour_data,
  output logic       sec_tick,
  output logic       min_tick
);

  set_state_e state_r;
  set_state_e state_nxt_s;

  logic [7:0] sec_r, min_r, hour_r;
  logic [7:0] sec_nxt_s, min_nxt_s, hour_nxt_s;
  logic       set_ready_r, set_err_r, sec_tick_r, min_tick_r;
  logic       xfer_s, load_s, reject_s, sec_due_s, advance_s, sec_wrap_s, min_wrap_s;

  tick_gen #(
    .SYSCLKHZ(SYSCLKHZ)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (Rst_n),
    .en     (En),
    .clr    (load_s),
    .sec_due(sec_due_s)
  );

  // Handshake decode; any accepted request suppresses a coincident advance.
  always_comb begin
    xfer_s     = set_valid && (state_r == ST_IDLE);
    load_s     = xfer_s && fields_ok(set_sec, set_min, set_hour);
    reject_s   = xfer_s && !load_s;
    advance_s  = sec_due_s && !xfer_s;
    sec_wrap_s = (sec_r == SEC_MAX);
    min_wrap_s = (min_r == MIN_MAX);
  end

  // Next time value: load, ripple-carry advance, or hold.
  always_comb begin
    sec_nxt_s  = sec_r;
    min_nxt_s  = min_r;
    hour_nxt_s = hour_r;
    if (load_s) begin
      sec_nxt_s  = set_sec;
      min_nxt_s  = set_min;
      hour_nxt_s = set_hour;
    end else if (advance_s) begin
      if (sec_wrap_s) begin
        sec_nxt_s = 8'd0;
        if (min_wrap_s) begin
          min_nxt_s = 8'd0;
          if (hour_r == HOUR_MAX) begin
            hour_nxt_s = HOUR_MIN;
          end else begin
            hour_nxt_s = hour_r + 8'd1;
          end
        end else begin
          min_nxt_s = min_r + 8'd1;
        end
      end else begin
        sec_nxt_s = sec_r + 8'd1;
      end
    end else begin
      sec_nxt_s = sec_r;
    end
  end

  // Set-FSM next state: COMMIT lasts exactly one cycle after any transfer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          state_nxt_s = ST_COMMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COMMIT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State, time and strobe registers.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= ST_IDLE;
      set_ready_r <= 1'b1;
      set_err_r   <= 1'b0;
      sec_tick_r  <= 1'b0;
      min_tick_r  <= 1'b0;
      sec_r       <= 8'd0;
      min_r       <= 8'd0;
      hour_r      <= HOUR_RST;
    end else begin
      state_r     <= state_nxt_s;
      set_ready_r <= (state_nxt_s == ST_IDLE);
      set_err_r   <= reject_s;
      sec_tick_r  <= advance_s;
      min_tick_r  <= advance_s && sec_wrap_s;
      sec_r       <= sec_nxt_s;
      min_r       <= min_nxt_s;
      hour_r      <= hour_nxt_s;
    end
  end

  assign set_ready = set_ready_r;
  assign set_err   = set_err_r;
  assign sec_tick  = sec_tick_r;
  assign min_tick  = min_tick_r;
  assign sec_data  = sec_r;
  assign min_data  = min_r;
  assign hour_data = hour_r;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper at SYSCLKHZ=10; hour expectations follow TIME_24H_EN.
module tb_time_keeper;

`ifdef TIME_24H_EN
  localparam logic [7:0] HR_RST = 8'd0;
  localparam logic [7:0] FULL_H = 8'd23;
  localparam logic [7:0] WRAP_H = 8'd0;
  localparam logic [7:0] BAD_H  = 8'd24;
`else
  localparam logic [7:0] HR_RST = 8'd12;
  localparam logic [7:0] FULL_H = 8'd12;
  localparam logic [7:0] WRAP_H = 8'd1;
  localparam logic [7:0] BAD_H  = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       Rst_n, En, set_valid, set_ready, set_err, sec_tick, min_tick;
  logic [7:0] set_sec, set_min, set_hour, sec_data, min_data, hour_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  time_keeper #(.SYSCLKHZ(10)) dut (
    .clk(clk), .Rst_n(Rst_n), .En(En), .set_valid(set_valid), .set_ready(set_ready),
    .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour), .set_err(set_err),
    .sec_data(sec_data), .min_data(min_data), .hour_data(hour_data),
    .sec_tick(sec_tick), .min_tick(min_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] cur_time();
    return {8'd0, hour_data, min_data, sec_data};
  endfunction

  function automatic logic [31:0] ticks();
    return {30'd0, min_tick, sec_tick};
  endfunction

  function automatic logic [31:0] hms(input logic [7:0] h, input logic [7:0] m,
                                      input logic [7:0] s);
    return {8'd0, h, m, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hour  = h;
    set_min   = m;
    set_sec   = s;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0; En = 1'b0; set_valid = 1'b0;
    set_sec = 8'd0; set_min = 8'd0; set_hour = 8'd0;
    repeat (2) step();

    // Reset values
    expect_val("rst_time", hms(HR_RST, 8'd0, 8'd0));
    expect_val("rst_ready", 32'd1);
    expect_val("rst_err", 32'd0);
    expect_val("rst_ticks", 32'd0);
    check_next(cur_time()); check_next({31'd0, set_ready});
    check_next({31'd0, set_err}); check_next(ticks());

    // 600 enabled cycles: sec_tick every 10th, single min_tick at 600
    Rst_n = 1'b1; En = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      expect_val("run_ticks", {30'd0, (c == 600), (c % 10 == 0)});
      step();
      check_next(ticks());
    end
    expect_val("run_time", hms(HR_RST, 8'd1, 8'd0));
    check_next(cur_time());

    // Full-day carry ripples in a single edge
    expect_val("full_load", hms(FULL_H, 8'd59, 8'd59));
    expect_val("full_ready", 32'd0);
    expect_val("full_ticks0", 32'd0);
    offer(FULL_H, 8'd59, 8'd59);
    check_next(cur_time()); check_next({31'd0, set_ready}); check_next(ticks());
    expect_val("full_hold", hms(FULL_H, 8'd59, 8'd59));
    repeat (9) step();
    check_next(cur_time());
    expect_val("full_wrap", hms(WRAP_H, 8'd0, 8'd0));
    expect_val("full_ticks", 32'd3);
    step();
    check_next(cur_time()); check_next(ticks());

    // Rejected loads: sec=60 and out-of-range hour
    for (int k = 0; k < 2; k++) begin
      expect_val("rej_err", 32'd1);
      expect_val("rej_ready", 32'd0);
      expect_val("rej_time", hms(WRAP_H, 8'd0, 8'd0));
      if (k == 0) offer(8'd1, 8'd0, 8'd60);
      else        offer(BAD_H, 8'd0, 8'd0);
      check_next({31'd0, set_err}); check_next({31'd0, set_ready}); check_next(cur_time());
      expect_val("rej_err_clr", 32'd0);
      expect_val("rej_ready_back", 32'd1);
      step();
      check_next({31'd0, set_err}); check_next({31'd0, set_ready});
    end

    // Load on the exact cycle prescaler=9 drops the tick
    offer(8'd3, 8'd30, 8'd30);
    repeat (9) step();
    expect_val("p9_time", hms(8'd5, 8'd10, 8'd20));
    expect_val("p9_ticks", 32'd0);
    offer(8'd5, 8'd10, 8'd20);
    check_next(cur_time()); check_next(ticks());
    expect_val("p9_quiet", 32'd0);
    repeat (9) step();
    check_next(ticks());
    expect_val("p9_tick", 32'd1);
    expect_val("p9_next", hms(8'd5, 8'd10, 8'd21));
    step();
    check_next(ticks()); check_next(cur_time());

    // En low for 25 cycles at prescaler=4
    offer(8'd2, 8'd0, 8'd0);
    repeat (4) step();
    En = 1'b0;
    for (int c = 0; c < 25; c++) begin
      expect_val("hold_state", {6'd0, min_tick, sec_tick, hour_data, min_data, sec_data} & 32'h0);
      expect_val("hold_time", hms(8'd2, 8'd0, 8'd0));
      step();
      check_next({30'd0, min_tick, sec_tick}); check_next(cur_time());
    end
    En = 1'b1;
    expect_val("resume_quiet", 32'd0);
    repeat (5) step();
    check_next(ticks());
    expect_val("resume_tick", 32'd1);
    expect_val("resume_time", hms(8'd2, 8'd0, 8'd1));
    step();
    check_next(ticks()); check_next(cur_time());

    // Reset asserted during COMMIT
    expect_val("commit_ready", 32'd0);
    offer(8'd7, 8'd7, 8'd7);
    check_next({31'd0, set_ready});
    #2 Rst_n = 1'b0;
    #1;
    expect_val("arst_time", hms(HR_RST, 8'd0, 8'd0));
    expect_val("arst_ready", 32'd1);
    expect_val("arst_err_ticks", 32'd0);
    check_next(cur_time()); check_next({31'd0, set_ready});
    check_next({29'd0, set_err, min_tick, sec_tick});
    step();
    Rst_n = 1'b1;
    expect_val("post_ready", 32'd1);
    expect_val("post_time", hms(HR_RST, 8'd0, 8'd0));
    step();
    check_next({31'd0, set_ready}); check_next(cur_time());

    if (exp_q.size() != 0) check("scoreboard_leftover", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter SYSCLKHZ, default 5000_0000, system clock frequency in Hz; one second = SYSCLKHZ cycles.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port En  input  1  count enable; 0 freezes time and prescaler.
REQ-005 SHALL have port set_valid  input  1  time-load request.
REQ-006 SHALL have port set_ready  output  1  load accept; transfer when set_valid&&set_ready.
REQ-007 SHALL have port set_sec / set_min / set_hour  input  8 each  load values, binary.
REQ-008 SHALL have port set_err  output  1  one-cycle pulse: offered load rejected (out of range).
REQ-009 SHALL have port sec_data / min_data / hour_data  output  8 each  current time, binary; feeds the per-hand PWM stages' time_data.
REQ-010 SHALL have port sec_tick / min_tick  output  1 each  one-cycle pulse coincident with the new sec/min value.

Function
REQ-011 SHALL run a prescaler 0..SYSCLKHZ-1; while En=1 and prescaler==SYSCLKHZ-1, the next edge wraps it to 0 and advances time.
REQ-012 SHALL, when En=0, hold prescaler and time unchanged, with ticks low.
REQ-013 SHALL advance sec 0..59; 59->0 carries into min 0..59; 59->0 carries into hour, all at the same edge.
REQ-014 SHALL wrap hour per REQ-024/025; a full 23:59:59 (or 12:59:59) carry ripples in one edge.
REQ-015 SHALL pulse sec_tick on every advance and min_tick only on sec 59->0, both registered, aligned with updated outputs.
REQ-016 SHALL run a 2-state FSM: IDLE (set_ready=1) and COMMIT (set_ready=0, one cycle), then back to IDLE.
REQ-017 SHALL, on a transfer with all fields in range, load the three values at that edge, clear the prescaler to 0, and enter COMMIT.
REQ-018 SHALL, on a transfer with any field out of range, leave time unchanged, pulse set_err next cycle, and enter COMMIT.
REQ-019 SHALL give set priority over a coincident advance; that tick is dropped and the ticks stay low.
REQ-020 SHALL keep set_valid ignored in COMMIT; the requester holds it until accepted.
REQ-021 SHALL register all outputs; no combinational input-to-output path except none at all (set_ready is an FSM decode).

Reset
REQ-022 SHALL, on Rst_n=0, asynchronously force prescaler=0, sec=0, min=0, state IDLE, set_ready=1, and set_err/sec_tick/min_tick=0; hour per REQ-024/025.
REQ-023 SHALL abandon a set in progress (COMMIT) on reset, with no partial load retained.

Configuration
REQ-024 SHALL, with TIME_24H_EN defined, count hour 0..23 (23->0), reset hour=0, and accept set_hour 0..23.
REQ-025 SHALL, without TIME_24H_EN, count hour 1..12 (12->1), reset hour=12, and accept set_hour 1..12 (0 rejected).

Structure
REQ-026 SHALL place SEC_MAX=59, MIN_MAX=59, HOUR_MIN/HOUR_MAX (macro-dependent) and the FSM state enum in shared package time_pkg.
REQ-027 SHALL instantiate one sub-module tick_gen (prescaler with En and sync clear) producing the one-cycle second strobe.

Verification (SYSCLKHZ=10)
REQ-028 SHALL verify: reset, En=1 for 600 cycles -> sec_tick every 10 cycles; at cycle 600 sec=0, min=1, and min_tick pulses once.
REQ-029 SHALL verify: load 23:59:59 (24H) then one tick -> 00:00:00 in one edge; 12H build load 12:59:59 -> 01:00:00.
REQ-030 SHALL verify: set_valid with sec=60 -> set_err pulses one cycle, time unchanged, set_ready low one cycle.
REQ-031 SHALL verify: set_valid on the exact cycle prescaler=9 -> loaded value appears, no sec_tick, next tick 10 cycles later.
REQ-032 SHALL verify: En=0 for 25 cycles mid-second (prescaler=4) -> no change; resumes and ticks 6 cycles after En=1.
REQ-033 SHALL verify: Rst_n low during COMMIT -> all outputs at reset values asynchronously, set_ready=1 after release.
